// File: rtl/rep_seq_pkg.sv
// Purpose: shared types for the a -> b[=N] -> c sequence monitor.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a; ports: none.
package rep_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT_B = 2'd1,
        WAIT_C  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_EXTRA_B = 2'b01,
        FC_TIMEOUT = 2'b10
    } fail_code_t;

    // Width needed to hold 0..max_val, never below one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rep_seq_sat_counter.sv
// Purpose: event counter that sticks at all-ones instead of wrapping.
// Latency: count reflects inc one edge later.
// Backpressure: none; ports clk, rst_n (async low), inc, count[W-1:0].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rep_seq_monitor.sv
// Purpose: hardware checker for "a |-> ##1 b[=REP_N] ##1 c", one attempt at a time.
// Latency: pass/fail/fail_code pulse the cycle after the deciding edge; counters update on that edge.
// Backpressure: none (pure observer); a arriving while busy is dropped and counted.
// Ports: clk, rst_n (async low), en, a, b, c in; busy, pass, fail, fail_code[1:0],
//        pass_cnt/fail_cnt/drop_cnt[CNT_W-1:0] out.
module rep_seq_monitor
    import rep_seq_pkg::*;
#(
    parameter int REP_N   = 3,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int BW = cnt_width(REP_N);
    localparam int WW = cnt_width(TIMEOUT);
    // b_cnt value just before the final required b arrives.
    localparam logic [BW-1:0] B_LAST = BW'(REP_N - 1);
    // wait_cnt value whose increment would reach TIMEOUT.
    localparam logic [WW-1:0] W_LAST = WW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t          state_q, state_d;
    logic [BW-1:0]   b_cnt_q, b_cnt_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            pass_q, pass_d;
    logic            fail_q, fail_d;
    fail_code_t      fc_q, fc_d;
    logic            active;
    logic            timeout_hit;
    logic            resolve;
    logic            drop_inc;

    assign active      = (state_q != IDLE);
    assign timeout_hit = (TIMEOUT > 0) && active && (wait_cnt_q == W_LAST);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            b_cnt_q    <= '0;
            wait_cnt_q <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            fc_q       <= FC_NONE;
        end else begin
            state_q    <= state_d;
            b_cnt_q    <= b_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            fc_q       <= fc_d;
        end
    end

    // Verdict for the current edge. Disable suppresses every verdict so an
    // abort never produces a pulse or touches the counters.
    always_comb begin
        pass_d   = 1'b0;
        fail_d   = 1'b0;
        fc_d     = FC_NONE;
        if (en) begin
            case (state_q)
                COUNT_B: begin
                    // c is meaningless here, even on the edge of the last b.
                    if (timeout_hit) begin
                        fail_d = 1'b1;
                        fc_d   = FC_TIMEOUT;
                    end
                end
                WAIT_C: begin
                    if (c) begin
                        pass_d = 1'b1;
                    end else if (b) begin
                        fail_d = 1'b1;
                        fc_d   = FC_EXTRA_B;
                    end else if (timeout_hit) begin
                        fail_d = 1'b1;
                        fc_d   = FC_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resolve  = pass_d | fail_d;
    // An a on a resolving edge starts the next attempt, so it is not a drop.
    assign drop_inc = en && a && active && !resolve;

    // Next state and attempt counters.
    always_comb begin
        state_d    = state_q;
        b_cnt_d    = b_cnt_q;
        wait_cnt_d = wait_cnt_q;
        if (!en) begin
            state_d = IDLE;
        end else if (!active || resolve) begin
            if (a) begin
                state_d    = COUNT_B;
                b_cnt_d    = '0;
                wait_cnt_d = '0;
            end else begin
                state_d    = IDLE;
            end
        end else begin
            if (TIMEOUT > 0) begin
                wait_cnt_d = wait_cnt_q + WW'(1);
            end
            if ((state_q == COUNT_B) && b) begin
                b_cnt_d = b_cnt_q + BW'(1);
                if (b_cnt_q == B_LAST) begin
                    state_d = WAIT_C;
                end
            end
        end
    end

    assign busy      = active;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fc_q;

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pass_d),
        .count (pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fail_d),
        .count (fail_cnt)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drop_inc),
        .count (drop_cnt)
    );

endmodule

// File: tb/tb_rep_seq_monitor.sv
// Purpose: self-checking bench for rep_seq_monitor (REP_N=3) with two instances:
//          dut (TIMEOUT=16, CNT_W=16) and dut_nt (TIMEOUT=0, CNT_W=2) on shared inputs.
// Latency: expectations are those seen one cycle after each driven edge.
// Backpressure: n/a.
module tb_rep_seq_monitor;

    logic        clk;
    logic        rst_n;
    logic        en, a, b, c;

    logic        busy, pass, fail;
    logic [1:0]  fail_code;
    logic [15:0] pass_cnt, fail_cnt, drop_cnt;

    logic        nt_busy, nt_pass, nt_fail;
    logic [1:0]  nt_fail_code;
    logic [1:0]  nt_pass_cnt, nt_fail_cnt, nt_drop_cnt;

    rep_seq_monitor #(.REP_N(3), .TIMEOUT(16), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .a         (a),
        .b         (b),
        .c         (c),
        .busy      (busy),
        .pass      (pass),
        .fail      (fail),
        .fail_code (fail_code),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt),
        .drop_cnt  (drop_cnt)
    );

    rep_seq_monitor #(.REP_N(3), .TIMEOUT(0), .CNT_W(2)) dut_nt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .a         (a),
        .b         (b),
        .c         (c),
        .busy      (nt_busy),
        .pass      (nt_pass),
        .fail      (nt_fail),
        .fail_code (nt_fail_code),
        .pass_cnt  (nt_pass_cnt),
        .fail_cnt  (nt_fail_cnt),
        .drop_cnt  (nt_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en, a, b, c;
        logic       busy, pass, fail;
        logic [1:0] fc;
        logic       chk_busy;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cur   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", nm, cur, act, exp);
        end
    endtask

    // i = {en,a,b,c}; o = {busy,pass,fail}
    function automatic vec_t mk(input logic [3:0] i, input logic [2:0] o,
                                input logic [1:0] fc = 2'b00, input logic cb = 1'b1);
        vec_t v;
        v.en = i[3]; v.a = i[2]; v.b = i[1]; v.c = i[0];
        v.busy = o[2]; v.pass = o[1]; v.fail = o[0];
        v.fc = fc; v.chk_busy = cb;
        return v;
    endfunction

    task automatic add(input logic [3:0] i, input logic [2:0] o,
                       input logic [1:0] fc = 2'b00, input logic cb = 1'b1);
        tbl.push_back(mk(i, o, fc, cb));
    endtask

    // Drive one edge's inputs, queue the expectation, compare after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        en = v.en; a = v.a; b = v.b; c = v.c;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        cur++;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard (step %0d): got empty queue, expected an entry", cur);
        end else begin
            e = exp_q.pop_front();
            if (e.chk_busy) chk("busy", 32'(busy), 32'(e.busy));
            chk("pass", 32'(pass), 32'(e.pass));
            chk("fail", 32'(fail), 32'(e.fail));
            chk("fail_code", 32'(fail_code), 32'(e.fc));
        end
    endtask

    task automatic attempt_pass();
        step(mk(4'b1100, 3'b100));
        step(mk(4'b1010, 3'b100));
        step(mk(4'b1010, 3'b100));
        step(mk(4'b1010, 3'b100));
        step(mk(4'b1001, 3'b010));
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 0);
        chk("rst pass", 32'(pass), 0);
        chk("rst fail", 32'(fail), 0);
        chk("rst fail_code", 32'(fail_code), 0);
        chk("rst pass_cnt", 32'(pass_cnt), 0);
        chk("rst fail_cnt", 32'(fail_cnt), 0);
        chk("rst drop_cnt", 32'(drop_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic pass: a@0, b@2,4,5, c@7
        add(4'b1100, 3'b100); add(4'b1000, 3'b100); add(4'b1010, 3'b100);
        add(4'b1000, 3'b100); add(4'b1010, 3'b100); add(4'b1010, 3'b100);
        add(4'b1000, 3'b100); add(4'b1001, 3'b010); add(4'b1000, 3'b000);
        // Extra b: a@0, b@1,2,3,5, c@6
        add(4'b1100, 3'b100); add(4'b1010, 3'b100); add(4'b1010, 3'b100);
        add(4'b1010, 3'b100); add(4'b1000, 3'b100); add(4'b1010, 3'b001, 2'b01);
        add(4'b1001, 3'b000);
        // c with the third b is ignored; next c passes
        add(4'b1100, 3'b100); add(4'b1010, 3'b100); add(4'b1010, 3'b100);
        add(4'b1011, 3'b100); add(4'b1001, 3'b010); add(4'b1000, 3'b000);
        // b and c together in WAIT_C passes
        add(4'b1100, 3'b100); add(4'b1010, 3'b100); add(4'b1010, 3'b100);
        add(4'b1010, 3'b100); add(4'b1011, 3'b010); add(4'b1000, 3'b000);
        // a@2 while busy is dropped, attempt still completes
        add(4'b1100, 3'b100); add(4'b1000, 3'b100); add(4'b1100, 3'b100);
        add(4'b1010, 3'b100); add(4'b1010, 3'b100); add(4'b1010, 3'b100);
        add(4'b1001, 3'b010); add(4'b1000, 3'b000);
        // a on the pass edge restarts; second pass 4 edges later
        add(4'b1100, 3'b100); add(4'b1010, 3'b100); add(4'b1010, 3'b100);
        add(4'b1010, 3'b100); add(4'b1101, 3'b110); add(4'b1010, 3'b100);
        add(4'b1010, 3'b100); add(4'b1010, 3'b100); add(4'b1001, 3'b010);
        add(4'b1000, 3'b000);
        // en low at edge 2 aborts; later b/c produce nothing
        add(4'b1100, 3'b100); add(4'b1010, 3'b100); add(4'b0010, 3'b000, 2'b00, 1'b0);
        add(4'b0010, 3'b000); add(4'b1001, 3'b000);
        // Timeout: a@0, b@1, fail code 10 after edge 16
        add(4'b1100, 3'b100); add(4'b1010, 3'b100);
        for (int k = 2; k < 16; k++) add(4'b1000, 3'b100);
        add(4'b1000, 3'b001, 2'b10); add(4'b1000, 3'b000);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        chk("pass_cnt after table", 32'(pass_cnt), 6);
        chk("fail_cnt after table", 32'(fail_cnt), 2);
        chk("drop_cnt after table", 32'(drop_cnt), 1);
        chk("nt pass_cnt saturated", 32'(nt_pass_cnt), 3);
        chk("nt fail_cnt", 32'(nt_fail_cnt), 1);
        chk("nt drop_cnt", 32'(nt_drop_cnt), 1);
        chk("nt busy no timeout", 32'(nt_busy), 1);

        for (int k = 0; k < 20; k++) step(mk(4'b1000, 3'b000));
        chk("nt busy still", 32'(nt_busy), 1);
        chk("nt no fail", 32'(nt_fail_cnt), 1);

        // Reset while waiting for c
        step(mk(4'b1100, 3'b100));
        step(mk(4'b1010, 3'b100));
        step(mk(4'b1010, 3'b100));
        step(mk(4'b1010, 3'b100));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst busy", 32'(busy), 0);
        chk("async rst pass", 32'(pass), 0);
        chk("async rst fail", 32'(fail), 0);
        chk("async rst pass_cnt", 32'(pass_cnt), 0);
        chk("async rst fail_cnt", 32'(fail_cnt), 0);
        chk("async rst drop_cnt", 32'(drop_cnt), 0);
        chk("async rst nt busy", 32'(nt_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Five passes: first proves a new a is accepted after reset
        for (int k = 0; k < 5; k++) attempt_pass();
        step(mk(4'b1000, 3'b000));
        chk("pass_cnt five", 32'(pass_cnt), 5);
        chk("nt pass_cnt five sat", 32'(nt_pass_cnt), 3);

        // Reset right after a pass edge kills the pending pulse
        attempt_pass();
        rst_n = 1'b0;
        #1;
        chk("rst kills pass", 32'(pass), 0);
        chk("rst kills busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(4'b1001, 3'b000));
        step(mk(4'b1000, 3'b000));
        chk("pass_cnt after rst", 32'(pass_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
